// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Address-map defaults, special encodings and the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF     = 32'h0040_0000;
  localparam logic [31:0] TEXT_LO_DEF      = 32'h0040_0000;
  localparam logic [31:0] TEXT_HI_DEF      = 32'h0040_0400;
  localparam logic [31:0] SYSCALL_INST_DEF = 32'h0000_000C;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // Word-aligned and inside [lo, hi], unsigned.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: valid/ready output side with a flush input.
// Priority is flush, then load, then drain on id_ready; otherwise hold.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        id_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  // Handshake: an entry is consumed on a cycle where id_valid && id_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_inst     <= in_inst;
      id_pc       <= in_pc;
      id_pc_plus4 <= in_pc + 32'd4;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per cycle from a
// zero-latency memory and hands it to decode; handles redirect, halt, fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] TEXT_LO      = TEXT_LO_DEF,
  parameter logic [31:0] TEXT_HI      = TEXT_HI_DEF,
  parameter logic [31:0] SYSCALL_INST = SYSCALL_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        fault
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         pc_ok;
  logic         load;
  logic         flush;

  assign imem_addr = pc;
  assign pc_ok     = pc_legal(pc, TEXT_LO, TEXT_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // A bad redirect target is not trapped here; it becomes the PC and the
  // legality check on the following cycle moves the FSM to FAULT.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    flush      = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          flush   = 1'b1;
        end else if (!pc_ok) begin
          state_next = ST_FAULT;
        end else if (!id_valid || id_ready) begin
          load    = 1'b1;
          pc_next = pc + 32'd4;
          if (imem_inst == SYSCALL_INST) state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          flush      = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  fetch_unit_if_id_reg u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .flush       (flush),
    .id_ready    (id_ready),
    .in_inst     (imem_inst),
    .in_pc       (pc),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

  assign halted = (state == ST_HALT) && !id_valid;
  assign fault  = (state == ST_FAULT);

endmodule
